// File: rtl/btn_pkg.sv
// Shared definitions for pushbutton conditioning: FSM state encoding,
// the debounce-length sanity check and pad polarity helper.
`ifndef BTN_PKG_SV
`define BTN_PKG_SV

// Elaboration-time guard: a debounce length below one cycle is meaningless.
`define BTN_CHECK_N(n) \
    if ((n) < 1) begin : g_bad_debounce_cycles \
        $error("button_conditioner: DEBOUNCE_CYCLES must be >= 1"); \
    end

package btn_pkg;

    typedef logic [1:0] btn_state_t;

    localparam btn_state_t RELEASED     = 2'd0;
    localparam btn_state_t PRESS_WAIT   = 2'd1;
    localparam btn_state_t PRESSED      = 2'd2;
    localparam btn_state_t RELEASE_WAIT = 2'd3;

    // Map a synchronized pad level to "button is pressed" (1 = pressed).
    function automatic logic pad_to_pressed(input logic pad, input logic active_low);
        return pad ^ active_low;
    endfunction

endpackage

`endif

// File: rtl/sync_2ff.sv
// Two-flop synchronizer for asynchronous pad inputs. Both stages reset to
// RESET_VALUE so a pad's idle level is presented while the system is in reset.
module sync_2ff #(
    parameter logic RESET_VALUE = 1'b0
) (
    input  logic clk,
    input  logic rst,
    input  logic d,
    output logic q
);

    logic meta;

    // Two-stage capture of the asynchronous input.
    always_ff @(posedge clk) begin
        if (rst) begin
            meta <= RESET_VALUE;
            q    <= RESET_VALUE;
        end else begin
            meta <= d;
            q    <= meta;
        end
    end

endmodule

// File: rtl/button_conditioner.sv
// Pushbutton conditioner: synchronizes a bouncing pad, debounces it with a
// four-state FSM and produces a clean level, press/release pulses and a
// press-toggle. A new level is accepted only after DEBOUNCE_CYCLES+1
// consecutive samples agree.
module button_conditioner
    import btn_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = 4,
    parameter bit ACTIVE_LOW      = 1'b1,
    parameter int CW              = $clog2(DEBOUNCE_CYCLES + 1)
) (
    input  logic clk,
    input  logic rst,
    input  logic btn,
    output logic pressed,
    output logic rise,
    output logic fall,
    output logic toggle
);

    `BTN_CHECK_N(DEBOUNCE_CYCLES)

    localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

    logic          btn_sync;
    logic          s;
    btn_state_t    state;
    logic [CW-1:0] cnt;

    // Idle pad level equals ACTIVE_LOW, so reset loads "not pressed".
    sync_2ff #(
        .RESET_VALUE(ACTIVE_LOW)
    ) u_sync (
        .clk(clk),
        .rst(rst),
        .d  (btn),
        .q  (btn_sync)
    );

    assign s = pad_to_pressed(btn_sync, ACTIVE_LOW);

    // Debounce FSM with qualification counter; all outputs registered.
    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= RELEASED;
            cnt     <= '0;
            pressed <= 1'b0;
            rise    <= 1'b0;
            fall    <= 1'b0;
            toggle  <= 1'b0;
        end else begin
            rise <= 1'b0;
            fall <= 1'b0;
            case (state)
                RELEASED: begin
                    if (s) begin
                        state <= PRESS_WAIT;
                        cnt   <= '0;
                    end
                end
                PRESS_WAIT: begin
                    if (!s) begin
                        state <= RELEASED;
                        cnt   <= '0;
                    end else if (cnt == CNT_LAST) begin
                        state   <= PRESSED;
                        cnt     <= '0;
                        pressed <= 1'b1;
                        rise    <= 1'b1;
                        toggle  <= ~toggle;
                    end else begin
                        cnt <= cnt + CW'(1);
                    end
                end
                PRESSED: begin
                    if (!s) begin
                        state <= RELEASE_WAIT;
                        cnt   <= '0;
                    end
                end
                RELEASE_WAIT: begin
                    if (s) begin
                        state <= PRESSED;
                        cnt   <= '0;
                    end else if (cnt == CNT_LAST) begin
                        state   <= RELEASED;
                        cnt     <= '0;
                        pressed <= 1'b0;
                        fall    <= 1'b1;
                    end else begin
                        cnt <= cnt + CW'(1);
                    end
                end
                default: begin
                    state <= RELEASED;
                    cnt   <= '0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_button_conditioner.sv
// Self-checking bench for button_conditioner. Two instances (active-low and
// active-high pads) share clock and reset. A reference model applies the
// qualification rule directly: the FSM sees the pad two edges late, and a new
// level is taken once N+1 consecutive samples differ from the current level.
module tb_button_conditioner;

    localparam int N = 4;

    logic clk = 1'b0;
    logic rst;
    logic btn_a, btn_b;
    logic pressed_a, rise_a, fall_a, toggle_a;
    logic pressed_b, rise_b, fall_b, toggle_b;

    int errors = 0;
    int checks = 0;
    int edge_cnt = 0;

    logic [7:0] obs;
    logic [7:0] exp_v;

    // reference model state, index 0 = active-low pad, 1 = active-high pad
    logic m_pipe [2][2];
    int   m_run  [2];
    logic m_lvl  [2];
    logic m_rise [2];
    logic m_fall [2];
    logic m_tog  [2];
    logic m_pad, m_s, m_inact;

    always #5 clk = ~clk;

    button_conditioner #(
        .DEBOUNCE_CYCLES(N),
        .ACTIVE_LOW     (1'b1)
    ) dut_a (
        .clk    (clk),
        .rst    (rst),
        .btn    (btn_a),
        .pressed(pressed_a),
        .rise   (rise_a),
        .fall   (fall_a),
        .toggle (toggle_a)
    );

    button_conditioner #(
        .DEBOUNCE_CYCLES(N),
        .ACTIVE_LOW     (1'b0)
    ) dut_b (
        .clk    (clk),
        .rst    (rst),
        .btn    (btn_b),
        .pressed(pressed_b),
        .rise   (rise_b),
        .fall   (fall_b),
        .toggle (toggle_b)
    );

    assign obs = {pressed_a, rise_a, fall_a, toggle_a, pressed_b, rise_b, fall_b, toggle_b};

    // reference model, evaluated on every rising edge from pre-edge inputs
    always @(posedge clk) begin
        edge_cnt++;
        for (int i = 0; i < 2; i++) begin
            m_inact = (i == 0) ? 1'b1 : 1'b0;
            m_pad   = (i == 0) ? btn_a : btn_b;
            if (rst) begin
                m_pipe[i][0] = m_inact;
                m_pipe[i][1] = m_inact;
                m_run[i]  = 0;
                m_lvl[i]  = 1'b0;
                m_rise[i] = 1'b0;
                m_fall[i] = 1'b0;
                m_tog[i]  = 1'b0;
            end else begin
                m_s = m_pipe[i][1] ^ m_inact;
                m_rise[i] = 1'b0;
                m_fall[i] = 1'b0;
                if (m_s != m_lvl[i]) m_run[i]++;
                else m_run[i] = 0;
                if (m_run[i] == N + 1) begin
                    m_lvl[i] = m_s;
                    m_run[i] = 0;
                    if (m_s) begin
                        m_rise[i] = 1'b1;
                        m_tog[i]  = ~m_tog[i];
                    end else begin
                        m_fall[i] = 1'b1;
                    end
                end
                m_pipe[i][1] = m_pipe[i][0];
                m_pipe[i][0] = m_pad;
            end
        end
        exp_v = {m_lvl[0], m_rise[0], m_fall[0], m_tog[0],
                 m_lvl[1], m_rise[1], m_fall[1], m_tog[1]};
    end

    // logical press request applied to both pads in their own polarity
    task automatic drive(input logic p);
        btn_a = ~p;
        btn_b = p;
    endtask

    task automatic test_reset;
        rst = 1'b1;
        drive(1'b0);
        repeat (2) begin
            @(negedge clk);
            checks++;
            if (obs !== 8'h00) begin
                errors++;
                $display("FAIL reset_idle obs=%b required=%b", obs, 8'h00);
            end
        end
        drive(1'b1);
        repeat (4) begin
            @(negedge clk);
            checks++;
            if (obs !== 8'h00) begin
                errors++;
                $display("FAIL reset_held obs=%b required=%b", obs, 8'h00);
            end
        end
        rst = 1'b0;
        drive(1'b0);
        repeat (8) begin
            @(negedge clk);
            checks++;
            if (obs !== exp_v) begin
                errors++;
                $display("FAIL after_reset obs=%b required=%b", obs, exp_v);
            end
        end
    endtask

    task automatic test_clean_press;
        int k;
        drive(1'b1);
        k = edge_cnt + 1;
        while (edge_cnt < k + 8) begin
            @(negedge clk);
            checks++;
            if (obs !== exp_v) begin
                errors++;
                $display("FAIL press_model edge=%0d obs=%b required=%b", edge_cnt, obs, exp_v);
            end
            if (edge_cnt == k + 5) begin
                checks++;
                if (obs !== 8'h00) begin
                    errors++;
                    $display("FAIL press_early obs=%b required=%b", obs, 8'h00);
                end
            end
            if (edge_cnt == k + 6) begin
                checks++;
                if (obs !== 8'b1101_1101) begin
                    errors++;
                    $display("FAIL press_edge obs=%b required=%b", obs, 8'b1101_1101);
                end
            end
            if (edge_cnt == k + 7) begin
                checks++;
                if (obs !== 8'b1001_1001) begin
                    errors++;
                    $display("FAIL press_hold obs=%b required=%b", obs, 8'b1001_1001);
                end
            end
        end
    endtask

    task automatic test_release;
        int k;
        logic [7:0] at6 [2];
        logic [7:0] at7 [2];
        at6[0] = 8'b0011_0011; at7[0] = 8'b0001_0001;
        at6[1] = 8'b1100_1100; at7[1] = 8'b1000_1000;
        for (int r = 0; r < 2; r++) begin
            // r=0: release with toggle held at 1; r=1: second press toggles to 0
            drive(r == 1);
            k = edge_cnt + 1;
            while (edge_cnt < k + 8) begin
                @(negedge clk);
                checks++;
                if (obs !== exp_v) begin
                    errors++;
                    $display("FAIL release_model edge=%0d obs=%b required=%b", edge_cnt, obs, exp_v);
                end
                if (edge_cnt == k + 6) begin
                    checks++;
                    if (obs !== at6[r]) begin
                        errors++;
                        $display("FAIL release_edge%0d obs=%b required=%b", r, obs, at6[r]);
                    end
                end
                if (edge_cnt == k + 7) begin
                    checks++;
                    if (obs !== at7[r]) begin
                        errors++;
                        $display("FAIL release_after%0d obs=%b required=%b", r, obs, at7[r]);
                    end
                end
            end
        end
        drive(1'b0);
        repeat (10) begin
            @(negedge clk);
            checks++;
            if (obs !== exp_v) begin
                errors++;
                $display("FAIL release_settle obs=%b required=%b", obs, exp_v);
            end
        end
    endtask

    task automatic test_glitch;
        int k;
        for (int len = N; len <= N + 1; len++) begin
            drive(1'b1);
            k = edge_cnt + 1;
            for (int c = 0; c < 16; c++) begin
                if (c == len) drive(1'b0);
                @(negedge clk);
                checks++;
                if (obs !== exp_v) begin
                    errors++;
                    $display("FAIL glitch_model len=%0d obs=%b required=%b", len, obs, exp_v);
                end
                if (len == N) begin
                    checks++;
                    if (obs !== 8'h00) begin
                        errors++;
                        $display("FAIL glitch_reject obs=%b required=%b", obs, 8'h00);
                    end
                end else if (edge_cnt == k + 6) begin
                    checks++;
                    if (obs !== 8'b1101_1101) begin
                        errors++;
                        $display("FAIL glitch_accept obs=%b required=%b", obs, 8'b1101_1101);
                    end
                end
            end
        end
    endtask

    task automatic test_bounce;
        int k;
        int rises;
        int rise_edge;
        rises = 0;
        rise_edge = -1;
        k = 0;
        for (int c = 0; c < 34; c++) begin
            if (c < 20) drive(((c / 2) % 2) == 0);
            else if (c == 20) begin
                drive(1'b1);
                k = edge_cnt + 1;
            end
            @(negedge clk);
            checks++;
            if (obs !== exp_v) begin
                errors++;
                $display("FAIL bounce_model obs=%b required=%b", obs, exp_v);
            end
            if (rise_a) begin
                rises++;
                rise_edge = edge_cnt;
            end
        end
        checks++;
        if (rises !== 1) begin
            errors++;
            $display("FAIL bounce_rises got=%0d required=%0d", rises, 1);
        end
        checks++;
        if (rise_edge !== k + 6) begin
            errors++;
            $display("FAIL bounce_timing edge=%0d required=%0d", rise_edge, k + 6);
        end
        drive(1'b0);
        repeat (12) @(negedge clk);
    endtask

    task automatic test_reset_mid;
        int e;
        int falls;
        falls = 0;
        drive(1'b1);
        repeat (10) @(negedge clk);
        checks++;
        if (obs[7] !== 1'b1 || obs[3] !== 1'b1) begin
            errors++;
            $display("FAIL mid_pre pressed=%b%b required=11", obs[7], obs[3]);
        end
        rst = 1'b1;
        @(negedge clk);
        checks++;
        if (obs !== 8'h00) begin
            errors++;
            $display("FAIL mid_clear obs=%b required=%b", obs, 8'h00);
        end
        rst = 1'b0;
        e = edge_cnt + 1;
        while (edge_cnt < e + 8) begin
            @(negedge clk);
            if (fall_a || fall_b) falls++;
            checks++;
            if (obs !== exp_v) begin
                errors++;
                $display("FAIL mid_model obs=%b required=%b", obs, exp_v);
            end
            if (edge_cnt == e + 6) begin
                checks++;
                if (obs !== 8'b1101_1101) begin
                    errors++;
                    $display("FAIL mid_requalify obs=%b required=%b", obs, 8'b1101_1101);
                end
            end
        end
        checks++;
        if (falls !== 0) begin
            errors++;
            $display("FAIL mid_no_fall got=%0d required=%0d", falls, 0);
        end
        drive(1'b0);
        repeat (12) @(negedge clk);
    endtask

    task automatic test_random;
        int la, lb;
        la = 0;
        lb = 0;
        for (int c = 0; c < 800; c++) begin
            if (la == 0) begin
                btn_a = 1'($urandom_range(0, 1));
                la = int'($urandom_range(1, 8));
            end
            if (lb == 0) begin
                btn_b = 1'($urandom_range(0, 1));
                lb = int'($urandom_range(1, 8));
            end
            la--;
            lb--;
            rst = ($urandom_range(0, 149) == 0);
            @(negedge clk);
            checks++;
            if (obs !== exp_v) begin
                errors++;
                $display("FAIL random_model cycle=%0d obs=%b required=%b", c, obs, exp_v);
            end
        end
        rst = 1'b0;
    endtask

    initial begin
        rst   = 1'b1;
        btn_a = 1'b1;
        btn_b = 1'b0;
        test_reset();
        test_clean_press();
        test_release();
        test_glitch();
        test_bounce();
        test_reset_mid();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
